// File: rtl/led_seq_pkg.sv
// led_seq_pkg: colour state encoding shared by the sequencer
// and the next-colour helper used by its FSM.
package led_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } state_e;

    // Colour reached by an advance press; BLUE wraps to RED, never IDLE.
    function automatic state_e next_color(state_e s);
        state_e n;
        case (s)
            IDLE:    n = RED;
            RED:     n = GREEN;
            GREEN:   n = BLUE;
            default: n = RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, level debounce and
// one-cycle pulse on each accepted 0->1 transition.
module button_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic press_pulse
);

    logic [1:0]  sync_q;
    logic        stable_q;
    logic        stable_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        press_q;
    logic        press_d;
    logic        level;

    assign level       = sync_q[1];
    assign press_pulse = press_q;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = 16'd0;
        press_d  = 1'b0;
        if (level != stable_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                stable_d = level;
                press_d  = level;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Synchroniser, debounce state and pulse register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= 16'd0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

endmodule

// File: rtl/led_color_sequencer.sv
// led_color_sequencer: debounced buttons step an RGB colour FSM;
// the selected LED is gated by a free-running PWM.
module led_color_sequencer
    import led_seq_pkg::*;
#(
    parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned       PWM_BITS        = 8,
    parameter logic [PWM_BITS:0] DUTY            = (PWM_BITS+1)'(128)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push_button0,
    input  logic push_button1,
    output logic led_red,
    output logic led_green,
    output logic led_blue
);

    logic                press0;
    logic                press1;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_on;
    state_e              state_q;
    state_e              state_d;
    logic                red_q;
    logic                green_q;
    logic                blue_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .raw         (push_button0),
        .press_pulse (press0)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .raw         (push_button1),
        .press_pulse (press1)
    );

    // Free-running PWM counter, wraps naturally at 2^PWM_BITS.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    assign pwm_on = ({1'b0, pwm_cnt_q} < DUTY);

    // Next colour: the return-to-idle button overrides advance.
    always_comb begin
        state_d = state_q;
        priority case (1'b1)
            press1:  state_d = IDLE;
            press0:  state_d = next_color(state_q);
            default: state_d = state_q;
        endcase
    end

    // Colour state and PWM-gated LED registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            red_q   <= 1'b0;
            green_q <= 1'b0;
            blue_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            red_q   <= (state_q == RED)   & pwm_on;
            green_q <= (state_q == GREEN) & pwm_on;
            blue_q  <= (state_q == BLUE)  & pwm_on;
        end
    end

    assign led_red   = red_q;
    assign led_green = green_q;
    assign led_blue  = blue_q;

endmodule

// File: tb/tb_led_color_sequencer.sv
// tb_led_color_sequencer: three duty variants share stimulus; a
// colour-level model feeds a queue checked by a PWM-window monitor.
module tb_led_color_sequencer;

    localparam int DB  = 4;
    localparam int WIN = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic b0      = 1'b0;
    logic b1      = 1'b0;
    logic [2:0] led0;
    logic [2:0] led1;
    logic [2:0] led2;

    int checks = 0;
    int fails  = 0;
    int color  = 0;
    int exp_q[$];
    int dutyv[3] = '{4, 0, 8};

    always #5 clock = ~clock;

    led_color_sequencer #(.DEBOUNCE_CYCLES(16'd4), .PWM_BITS(3), .DUTY(4'd4)) u0 (
        .clock(clock), .reset_n(reset_n),
        .push_button0(b0), .push_button1(b1),
        .led_red(led0[0]), .led_green(led0[1]), .led_blue(led0[2])
    );

    led_color_sequencer #(.DEBOUNCE_CYCLES(16'd4), .PWM_BITS(3), .DUTY(4'd0)) u1 (
        .clock(clock), .reset_n(reset_n),
        .push_button0(b0), .push_button1(b1),
        .led_red(led1[0]), .led_green(led1[1]), .led_blue(led1[2])
    );

    led_color_sequencer #(.DEBOUNCE_CYCLES(16'd4), .PWM_BITS(3), .DUTY(4'd8)) u2 (
        .clock(clock), .reset_n(reset_n),
        .push_button0(b0), .push_button1(b1),
        .led_red(led2[0]), .led_green(led2[1]), .led_blue(led2[2])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int advance(input int c);
        return (c == 3) ? 1 : c + 1;
    endfunction

    // Hand the expected colour to the monitor and wait for it to finish.
    task automatic expect_color();
        int n;
        exp_q.push_back(color);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("monitor_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Hold the buttons for len sampled cycles, release, update model.
    task automatic op(input bit p0, input bit p1, input int len);
        @(negedge clock);
        b0 = p0;
        b1 = p1;
        repeat (len) @(negedge clock);
        b0 = 1'b0;
        b1 = 1'b0;
        if (len >= DB) begin
            if (p1)      color = 0;
            else if (p0) color = advance(color);
        end
        repeat (10) @(negedge clock);
        expect_color();
    endtask

    // Monitor: observe one PWM window per expected colour.
    initial begin
        logic [2:0] h0 [WIN];
        int e;
        int cnt [3][3];
        int multi;
        int bad;
        int want;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                multi = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        cnt[i][j] = 0;
                for (int t = 0; t < WIN; t++) begin
                    h0[t] = led0;
                    for (int j = 0; j < 3; j++) begin
                        cnt[0][j] += int'(led0[j]);
                        cnt[1][j] += int'(led1[j]);
                        cnt[2][j] += int'(led2[j]);
                    end
                    if ($countones(led0) > 1 || $countones(led1) > 1 ||
                        $countones(led2) > 1)
                        multi++;
                    @(negedge clock);
                end
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        want = (e == j + 1) ?
                               2 * ((dutyv[i] > 8) ? 8 : dutyv[i]) : 0;
                        chk($sformatf("led_on_cnt c%0d d%0d l%0d", e, dutyv[i], j),
                            cnt[i][j], want);
                    end
                end
                chk("one_hot", multi, 0);
                bad = 0;
                for (int t = 0; t < 8; t++)
                    if (h0[t] != h0[t+8]) bad++;
                chk("pwm_period8", bad, 0);
                void'(exp_q.pop_front());
            end
        end
    end

    // Stimulus: directed scenarios, then random presses.
    initial begin
        int len;
        int kind;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        expect_color();

        op(1, 0, 10);
        op(1, 0, 5);
        op(1, 0, DB);
        op(1, 0, 6);
        op(1, 0, DB - 1);
        op(1, 0, DB);
        op(1, 1, 6);
        op(1, 0, 7);

        @(negedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_leds", int'({led0, led1, led2}), 0);
        color = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        expect_color();

        op(1, 0, 8);
        b0 = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("reset_held_btn_leds", int'({led0, led1, led2}), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        color = 0;
        repeat (12) @(negedge clock);
        b0 = 1'b0;
        color = 1;
        repeat (10) @(negedge clock);
        expect_color();

        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 7);
            len  = $urandom_range(1, 10);
            if (kind < 5)      op(1, 0, len);
            else if (kind < 7) op(0, 1, len);
            else               op(1, 1, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
